// File: rtl/mtx_sync_seq.sv
// mtx_sync_seq: multi-channel TX sync sequencer (PRE/MARK/BLANK/SETTLE then RUN) gating NCH IQ channels.
// Optional MTX_SYNC_SEQ_EXT_TRIG_EN: start on synchronised ext_trig rising edge qualified by sync_ready.
module mtx_sync_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int NCH = 2,
  parameter int CNT_WIDTH = 24,
  parameter int GPIO_REG_WIDTH = 12,
  parameter logic [GPIO_REG_WIDTH-1:0] SYNC_MASK = 12'h001,
  parameter logic [GPIO_REG_WIDTH-1:0] TX_MASK = 12'h010
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      sync_ready,
  input  logic                      ext_trig,
  input  logic [CNT_WIDTH-1:0]      sync_len,
  input  logic [NCH-1:0]            ch_en,
  input  logic [NCH*DATA_WIDTH-1:0] in_i,
  input  logic [NCH*DATA_WIDTH-1:0] in_q,
  output logic [NCH*DATA_WIDTH-1:0] out_i,
  output logic [NCH*DATA_WIDTH-1:0] out_q,
  output logic                      out_valid,
  output logic                      srst,
  output logic [GPIO_REG_WIDTH-1:0] gpio_out,
  output logic                      busy,
  output logic [2:0]                state
);
  localparam logic [2:0] IDLE = 3'd0, PRE = 3'd1, MARK = 3'd2, BLANK = 3'd3, SETTLE = 3'd4, RUN = 3'd5;
  logic                      s, live, last;
  logic [CNT_WIDTH-1:0]      cnt, len;
  logic [NCH-1:0]            ch_l;
  logic [NCH*DATA_WIDTH-1:0] ni, nq;
`ifdef MTX_SYNC_SEQ_EXT_TRIG_EN
  logic t_meta, t_sync, t_prev;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {t_meta, t_sync, t_prev} <= '0;
    else {t_meta, t_sync, t_prev} <= {ext_trig, t_meta, t_sync};
  assign s = t_sync & ~t_prev & sync_ready;
`else
  logic sr_prev, unused_trig;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sr_prev <= 1'b0;
    else sr_prev <= sync_ready;
  assign s = sync_ready & ~sr_prev;
  assign unused_trig = ext_trig;
`endif
  assign busy = state >= PRE && state <= SETTLE;
  assign srst = state <= BLANK;
  assign live = state == PRE || state == MARK || state == SETTLE || state == RUN;
  assign last = cnt == len;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      len <= '0;
      ch_l <= '0;
    end else if (s && (state == IDLE || state == RUN)) begin
      state <= PRE;
      cnt <= CNT_WIDTH'(1);
      len <= sync_len == '0 ? CNT_WIDTH'(1) : sync_len;
      ch_l <= ch_en;
    end else if (busy) begin
      state <= last ? state + 3'd1 : state;
      cnt <= last ? CNT_WIDTH'(1) : cnt + CNT_WIDTH'(1);
    end
  always_comb begin
    ni = '0;
    nq = '0;
    for (int k = 0; k < NCH; k++) begin
      ni[k*DATA_WIDTH +: DATA_WIDTH] = live && ch_l[k] ? in_i[k*DATA_WIDTH +: DATA_WIDTH] : '0;
      nq[k*DATA_WIDTH +: DATA_WIDTH] = live && ch_l[k] ? in_q[k*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      out_i <= '0;
      out_q <= '0;
      out_valid <= 1'b0;
      gpio_out <= '0;
    end else begin
      out_i <= ni;
      out_q <= nq;
      out_valid <= live;
      gpio_out <= (state == MARK || state == BLANK ? SYNC_MASK : '0) | (live && |ch_l ? TX_MASK : '0);
    end
endmodule

// File: tb/tb_mtx_sync_seq.sv
// tb_mtx_sync_seq: directed self-checking bench for mtx_sync_seq (default 2 channels x 16 bits).
module tb_mtx_sync_seq;
  logic        clk = 1'b0, reset_n = 1'b1, sync_ready = 1'b0, ext_trig = 1'b0;
  logic [23:0] sync_len = '0;
  logic [1:0]  ch_en = '0;
  logic [31:0] in_i = '0, in_q = '0, out_i, out_q;
  logic        out_valid, srst, busy;
  logic [11:0] gpio_out;
  logic [2:0]  state;
  int checks = 0, failures = 0;
`ifdef MTX_SYNC_SEQ_EXT_TRIG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  mtx_sync_seq dut (
    .clk(clk), .reset_n(reset_n), .sync_ready(sync_ready), .ext_trig(ext_trig),
    .sync_len(sync_len), .ch_en(ch_en), .in_i(in_i), .in_q(in_q),
    .out_i(out_i), .out_q(out_q), .out_valid(out_valid), .srst(srst),
    .gpio_out(gpio_out), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic live_f(input logic [2:0] s);
    return s == 3'd1 || s == 3'd2 || s == 3'd4 || s == 3'd5;
  endfunction

  function automatic logic [11:0] gpio_f(input logic [2:0] s, input logic [1:0] che);
    return (s == 3'd2 || s == 3'd3 ? 12'h001 : 12'h000) | (live_f(s) && |che ? 12'h010 : 12'h000);
  endfunction

  function automatic logic [31:0] dat_f(input logic [2:0] s, input logic [1:0] che, input logic [31:0] x);
    return {live_f(s) && che[1] ? x[31:16] : 16'h0, live_f(s) && che[0] ? x[15:0] : 16'h0};
  endfunction

  function automatic logic [2:0] exp_state(input int len, input int c);
    return c <= 4 * len ? 3'(1 + (c - 1) / len) : 3'd5;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start();
    int n;
    sync_ready = 1'b0;
    ext_trig = 1'b0;
    @(negedge clk);
    sync_ready = 1'b1;
`ifdef MTX_SYNC_SEQ_EXT_TRIG_EN
    ext_trig = 1'b1;
`endif
    n = 0;
    do begin
      @(negedge clk);
      n++;
      ext_trig = 1'b0;
    end while (state !== 3'd1 && n < 20);
    chk("start_lat", 32'(n), 32'(LAT));
  endtask

  // Expected registered outputs at each sample follow the state seen one sample earlier.
  task automatic run_frame(input int len, input logic [1:0] che, input logic [2:0] prev0, input logic [1:0] pche);
    logic [2:0] ps, es;
    logic [1:0] pc;
    ps = prev0;
    pc = pche;
    for (int c = 1; c <= 4 * len + 2; c++) begin
      if (c > 1) @(negedge clk);
      es = exp_state(len, c);
      chk("state", 32'(state), 32'(es));
      chk("srst", 32'(srst), 32'(es <= 3'd3));
      chk("busy", 32'(busy), 32'(es >= 3'd1 && es <= 3'd4));
      chk("valid", 32'(out_valid), 32'(live_f(ps)));
      chk("gpio", 32'(gpio_out), 32'(gpio_f(ps, pc)));
      chk("out_i", out_i, dat_f(ps, pc, in_i));
      chk("out_q", out_q, dat_f(ps, pc, in_q));
      ps = es;
      pc = che;
    end
  endtask

  initial begin
    #2 reset_n = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_srst", 32'(srst), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_gpio", 32'(gpio_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out", out_i | out_q, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    step(2);
    ext_trig = 1'b1;
    step(1);
    ext_trig = 1'b0;
    step(5);
    chk("trig_no_ready", 32'(state), 32'd0);

    sync_len = 24'd4; ch_en = 2'b11; in_i = 32'h2222_1111; in_q = 32'h4444_3333;
    start();
    run_frame(4, 2'b11, 3'd0, 2'b00);
    chk("run_out_q", out_q, 32'h4444_3333);
    sync_ready = 1'b0;
    step(3);
    chk("run_hold", 32'(state), 32'd5);

    sync_len = 24'd2; ch_en = 2'b01; in_i = 32'h7FFF_1234; in_q = 32'h7FFF_5678;
    start();
    run_frame(2, 2'b01, 3'd5, 2'b11);
    chk("ch1_gated", out_i, 32'h0000_1234);
    chk("tx_mask", 32'(gpio_out), 32'h010);

    sync_len = 24'd0; ch_en = 2'b11;
    start();
    run_frame(1, 2'b11, 3'd5, 2'b01);

    sync_len = 24'd3;
    start();
    step(3);
    chk("in_mark", 32'(state), 32'd2);
    sync_ready = 1'b0;
    step(1);
    sync_ready = 1'b1;
    ext_trig = 1'b1;
    step(1);
    ext_trig = 1'b0;
    step(1);
    chk("ignore_busy", 32'(state), 32'd3);
    step(6);
    chk("run_after_ign", 32'(state), 32'd5);
    sync_len = 24'd2;
    start();
    step(7);
    chk("relatch_settle", 32'(state), 32'd4);
    step(1);
    chk("relatch_run", 32'(state), 32'd5);

    start();
    step(2);
    #2 reset_n = 1'b0;
    sync_ready = 1'b0;
    #1;
    chk("mid_state", 32'(state), 32'd0);
    chk("mid_srst", 32'(srst), 32'd1);
    chk("mid_valid", 32'(out_valid), 32'd0);
    chk("mid_gpio", 32'(gpio_out), 32'd0);
    chk("mid_out", out_i | out_q, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    step(4);
    chk("idle_after_rst", 32'(state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
